// File: rtl/instruction_mem_ctrl.sv
// Instruction memory with a byte-addressed fetch port, loader write port and post-reset clear sweep.
// Define IMEM_PARITY_EN to store a per-word even-parity bit and add the load_par_flip injection input.
module instruction_mem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [63:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [1:0]  fetch_cause,
  input  logic        load_we,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic        load_par_flip,
`endif
  output logic        load_busy
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = 33;
`else
  localparam int unsigned MEM_W = 32;
`endif

  localparam logic [1:0] CAUSE_OK     = 2'b00;
  localparam logic [1:0] CAUSE_MISAL  = 2'b01;
  localparam logic [1:0] CAUSE_RANGE  = 2'b10;
  localparam logic [1:0] CAUSE_PARITY = 2'b11;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  typedef struct packed {
    logic             misal;
    logic             oor;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Shared by both ports so fetch and load agree on what is a legal address.
  function automatic dec_t decode(input logic [63:0] addr);
    logic [63:0] off;
    dec_t        d;
    off     = addr - BASE_ADDR;
    d.misal = (addr[1:0] != 2'b00);
    d.oor   = (addr < BASE_ADDR) || ((off >> (IDX_W + 2)) != 64'd0);
    d.idx   = IDX_W'(off >> 2);
    return d;
  endfunction

  function automatic logic even_par(input logic [31:0] data);
    return ^data;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [31:0]      fetch_instr_q, fetch_instr_d;
  logic [1:0]       fetch_cause_q, fetch_cause_d;

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [MEM_W-1:0] mem_wdata;

  dec_t             fdec, ldec;
  logic             fetch_accept;
  logic [MEM_W-1:0] rd_word;
  logic             par_err;

  assign fdec         = decode(fetch_addr);
  assign ldec         = decode(load_addr);
  assign fetch_ready  = (state_q == ST_RUN);
  assign load_busy    = (state_q == ST_CLEAR);
  assign fetch_accept = fetch_req && fetch_ready;
  assign rd_word      = mem_q[fdec.idx];

`ifdef IMEM_PARITY_EN
  assign par_err = ^rd_word;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + IDX_W'(1);
      if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // The sweep owns the write port in CLEAR, so loads cannot race it.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_widx = clr_cnt_q;
    end else if (load_we && !ldec.misal && !ldec.oor) begin
      mem_we   = 1'b1;
      mem_widx = ldec.idx;
`ifdef IMEM_PARITY_EN
      mem_wdata = {even_par(load_data) ^ load_par_flip, load_data};
`else
      mem_wdata = load_data;
`endif
    end
  end

  always_comb begin
    fetch_valid_d = fetch_accept;
    fetch_instr_d = fetch_instr_q;
    fetch_cause_d = fetch_cause_q;
    if (fetch_accept) begin
      fetch_instr_d = 32'h0;
      if (fdec.misal) begin
        fetch_cause_d = CAUSE_MISAL;
      end else if (fdec.oor) begin
        fetch_cause_d = CAUSE_RANGE;
      end else if (par_err) begin
        fetch_cause_d = CAUSE_PARITY;
      end else begin
        fetch_cause_d = CAUSE_OK;
        fetch_instr_d = rd_word[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'h0;
      fetch_cause_q <= CAUSE_OK;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_cause_q <= fetch_cause_d;
    end
  end

  // Storage is not reset; the sweep zeroes it. Reading before this write gives read-before-write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_cause = fetch_cause_q;

endmodule

// File: tb/tb_instruction_mem_ctrl.sv
// Self-checking bench for instruction_mem_ctrl: vector table, hand sequences and a randomized model run.
module tb_instruction_mem_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [1:0]  fetch_cause;
  logic        load_we = 1'b0;
  logic [63:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_par_flip = 1'b0;
  logic        load_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: word contents, corrupted-parity flags and the expected output registers.
  logic [31:0] mdl [DEPTH];
  bit          mbad [DEPTH];
  logic        exp_valid;
  logic [31:0] exp_instr;
  logic [1:0]  exp_cause;

  instruction_mem_ctrl #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_cause(fetch_cause),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [63:0] faddr;
    logic        we;
    logic [63:0] laddr;
    logic [31:0] ldata;
    logic        evalid;
    logic [31:0] einstr;
    logic [1:0]  ecause;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(4 * DEPTH));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]  = 32'h0;
      mbad[i] = 1'b0;
    end
    exp_valid = 1'b0;
    exp_instr = 32'h0;
    exp_cause = 2'b00;
  endtask

  task automatic model_fetch(input logic req, input logic [63:0] a);
    int unsigned idx;
    exp_valid = req;
    if (req) begin
      exp_instr = 32'h0;
      if (a[1:0] != 2'b00) exp_cause = 2'b01;
      else if (!in_range(a)) exp_cause = 2'b10;
      else begin
        idx = int'((a - BASE) / 4);
        if (mbad[idx]) exp_cause = 2'b11;
        else begin
          exp_cause = 2'b00;
          exp_instr = mdl[idx];
        end
      end
    end
  endtask

  task automatic model_load(input logic we, input logic [63:0] a, input logic [31:0] d, input logic flip);
    int unsigned idx;
    if (we && a[1:0] == 2'b00 && in_range(a)) begin
      idx = int'((a - BASE) / 4);
      mdl[idx]  = d;
      mbad[idx] = flip;
    end
  endtask

  // Drives one cycle of stimulus, advances the model (fetch before load), samples 1 unit after the edge.
  task automatic step(input logic req, input logic [63:0] fa, input logic we,
                      input logic [63:0] la, input logic [31:0] ld, input logic flip);
    fetch_req = req;  fetch_addr = fa;
    load_we = we;     load_addr = la;  load_data = ld;  load_par_flip = flip;
    model_fetch(req, fa);
    model_load(we, la, ld, flip);
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    load_we = 1'b0;
    load_par_flip = 1'b0;
  endtask

  task automatic check_exp(input string tag);
    chk({tag, "_valid"}, 64'(fetch_valid), 64'(exp_valid));
    chk({tag, "_instr"}, 64'(fetch_instr), 64'(exp_instr));
    chk({tag, "_cause"}, 64'(fetch_cause), 64'(exp_cause));
  endtask

  // Counts edges until fetch_ready rises, bounded so a stuck sweep cannot hang the run.
  task automatic sweep_len(output int n);
    n = 0;
    while (!fetch_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
      3:       return BASE + 64'($urandom_range(0, 4 * DEPTH - 1));
      4:       return BASE - 64'(4 * $urandom_range(1, 4));
      default: return BASE + 64'(4 * DEPTH + 4 * $urandom_range(0, 8));
    endcase
  endfunction

  initial begin
    int n;
    tbl[0]  = '{1'b0, 64'h0,           1'b1, 64'h8000_0004, 32'h0050_0093, 1'b0, 32'h0,          2'b00};
    tbl[1]  = '{1'b1, 64'h8000_0004,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0050_0093, 2'b00};
    tbl[2]  = '{1'b1, 64'h8000_0002,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0,          2'b01};
    tbl[3]  = '{1'b1, 64'h7FFF_FFFC,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0,          2'b10};
    tbl[4]  = '{1'b1, 64'h8000_0040,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0,          2'b10};
    tbl[5]  = '{1'b0, 64'h0,           1'b1, 64'h8000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0,          2'b10};
    tbl[6]  = '{1'b0, 64'h0,           1'b1, 64'h8000_000C, 32'hAAAA_AAAA, 1'b0, 32'h0,          2'b10};
    tbl[7]  = '{1'b1, 64'h8000_000C,   1'b1, 64'h8000_000C, 32'h5555_5555, 1'b1, 32'hAAAA_AAAA, 2'b00};
    tbl[8]  = '{1'b1, 64'h8000_000C,   1'b0, 64'h0,         32'h0,         1'b1, 32'h5555_5555, 2'b00};
    tbl[9]  = '{1'b0, 64'h0,           1'b1, 64'h8000_0005, 32'h1234_5678, 1'b0, 32'h5555_5555, 2'b00};
    tbl[10] = '{1'b1, 64'h8000_0004,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0050_0093, 2'b00};
    tbl[11] = '{1'b1, 64'h8000_0000,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0,          2'b00};
    tbl[12] = '{1'b1, 64'h8000_003C,   1'b0, 64'h0,         32'h0,         1'b1, 32'h0,          2'b00};

    model_reset();

    // Power-on reset values, then the clear sweep length.
    #12;
    chk("rst_ready", 64'(fetch_ready), 64'd0);
    chk("rst_busy",  64'(load_busy),   64'd1);
    chk("rst_valid", 64'(fetch_valid), 64'd0);
    chk("rst_instr", 64'(fetch_instr), 64'd0);
    chk("rst_cause", 64'(fetch_cause), 64'd0);
    reset = 1'b0;
    sweep_len(n);
    chk("sweep_edges", 64'(n), 64'(DEPTH));
    chk("sweep_busy",  64'(load_busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].req, tbl[i].faddr, tbl[i].we, tbl[i].laddr, tbl[i].ldata, 1'b0);
      chk($sformatf("vec%0d_valid", i), 64'(fetch_valid), 64'(tbl[i].evalid));
      chk($sformatf("vec%0d_instr", i), 64'(fetch_instr), 64'(tbl[i].einstr));
      chk($sformatf("vec%0d_cause", i), 64'(fetch_cause), 64'(tbl[i].ecause));
    end

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 1)),
           rand_addr(), $urandom, 1'b0);
      check_exp($sformatf("rnd%0d", i));
    end

    // Streaming fetches interrupted by an asynchronous reset between edges.
    fetch_req = 1'b1;
    fetch_addr = BASE + 64'd4;
    repeat (3) @(posedge clk);
    #3;
    chk("stream_valid", 64'(fetch_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(fetch_valid), 64'd0);
    chk("async_instr", 64'(fetch_instr), 64'd0);
    chk("async_cause", 64'(fetch_cause), 64'd0);
    chk("async_ready", 64'(fetch_ready), 64'd0);
    chk("async_busy",  64'(load_busy),   64'd1);
    fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    sweep_len(n);
    chk("resweep_edges", 64'(n), 64'(DEPTH));
    step(1'b1, BASE + 64'd4, 1'b0, 64'h0, 32'h0, 1'b0);
    check_exp("after_rst_w1");
    chk("after_rst_w1_zero", 64'(fetch_instr), 64'd0);
    step(1'b1, BASE + 64'hC, 1'b0, 64'h0, 32'h0, 1'b0);
    check_exp("after_rst_w3");

`ifdef IMEM_PARITY_EN
    step(1'b0, 64'h0, 1'b1, BASE + 64'd8, 32'h1, 1'b1);
    step(1'b1, BASE + 64'd8, 1'b0, 64'h0, 32'h0, 1'b0);
    chk("par_bad_cause", 64'(fetch_cause), 64'd3);
    chk("par_bad_instr", 64'(fetch_instr), 64'd0);
    step(1'b0, 64'h0, 1'b1, BASE + 64'd8, 32'h1, 1'b0);
    step(1'b1, BASE + 64'd8, 1'b0, 64'h0, 32'h0, 1'b0);
    chk("par_ok_cause", 64'(fetch_cause), 64'd0);
    chk("par_ok_instr", 64'(fetch_instr), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_mem_ctrl.md
# instruction_mem_ctrl

Parametrised instruction memory for the RV64 single-cycle core, replacing the fixed 1024-word array. It adds a byte-addressed fetch port with a valid/ready handshake and registered read data, and a separate loader write port for program download. It also runs a hardware clear sweep after reset and reports fetch faults: misaligned, out-of-range, and optionally parity. The block sits between the PC/fetch logic and the testbench or boot loader.

## Interface
- DEPTH, 1024, number of 32-bit instruction words; power of two, 16..65536
- BASE_ADDR, 64'h0, byte address that maps to word 0
- IDX_W, $clog2(DEPTH), word-index width; derived, do not override
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request
- fetch_addr  in  64  byte address of the instruction (PC)
- fetch_ready  out  1  fetch port can accept a request
- fetch_valid  out  1  fetch_instr/fetch_cause valid; one-cycle pulse
- fetch_instr  out  32  fetched instruction word
- fetch_cause  out  2  00 ok, 01 misaligned, 10 out of range, 11 parity error
- load_we  in  1  loader write strobe
- load_addr  in  64  loader byte address
- load_data  in  32  word to write
- load_busy  out  1  loader writes are ignored while high

## Operation
- Address decode, identical on both ports: off = addr - BASE_ADDR (64-bit, wrapping); idx = off[IDX_W+1:2].
- Misaligned: addr[1:0] != 0.
- Out of range: addr < BASE_ADDR (unsigned), or off[63:IDX_W+2] != 0.
- Fault priority: misaligned > out of range > parity.
- State machine with two states, CLEAR and RUN.
  - CLEAR: clr_cnt counts 0..DEPTH-1 and writes 32'h0 to memory[clr_cnt], one word per cycle. After the write to DEPTH-1 the FSM goes to RUN. In CLEAR, fetch_ready=0 and load_busy=1. Loads and fetch_req are ignored, and no fault is raised.
  - RUN: fetch_ready=1 and load_busy=0.
- Fetch: accepted when fetch_req && fetch_ready.
  - On fault: fetch_instr=32'h0 and fetch_cause carries the fault code.
  - Otherwise: fetch_instr=memory[idx] and fetch_cause=00.
  - fetch_instr and fetch_cause hold their value until the next accepted fetch.
- Load: when load_we && !load_busy, the word is written only if the address is aligned and in range; bad loads are silently dropped.
- Simultaneous fetch and load to the same idx: the fetch returns the old word (read-before-write). The new word is visible to fetches accepted the following cycle.
- Reset asserted at any time, including mid-CLEAR or mid-fetch:
  - Immediately: FSM=CLEAR, clr_cnt=0, fetch_valid=0, fetch_instr=0, fetch_cause=00, fetch_ready=0, load_busy=1.
  - The sweep restarts from 0 after reset deasserts.

## Timing
- Reset values: fetch_ready=0, fetch_valid=0, fetch_instr=32'h0, fetch_cause=2'b00, load_busy=1.
- First edge after reset deassert is sweep cycle 0. fetch_ready rises after DEPTH edges: RUN is entered on the edge that writes word DEPTH-1.
- Fetch latency is 1 cycle: a request accepted at edge N gives fetch_valid=1 during cycle N..N+1.
- Back-to-back fetches every cycle are supported, so fetch_valid stays high continuously.
- A load accepted at edge N is visible to a fetch accepted at edge N+1 or later.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an even-parity bit. Load writes compute it; the CLEAR sweep stores 0.
  - A fetch whose stored parity mismatches returns fetch_cause=11 and fetch_instr=0.
  - Adds input load_par_flip (1 bit): when high with an accepted load, the stored parity bit is inverted. This port is for fault injection only.
- IMEM_PARITY_EN undefined: no parity storage, no load_par_flip port, and cause 11 never occurs.

## Test plan
- Reset sweep, DEPTH=16: deassert reset → fetch_ready=0 and load_busy=1 for exactly 16 edges, then both flip. A fetch of 0x0 then returns 32'h0 with cause 00.
- Load then fetch, BASE_ADDR=0x8000_0000: load 0x00500093 at 0x8000_0004, fetch 0x8000_0004 next cycle → fetch_valid one cycle later with instr 0x00500093 and cause 00.
- Faults:
  - fetch 0x8000_0002 → cause 01, instr 0.
  - fetch 0x7FFF_FFFC → cause 10.
  - fetch 0x8000_0040 with DEPTH=16 → cause 10.
  - load to 0x8000_0040 → no word changes.
- Same-cycle collision: word 3 = 0xAAAA_AAAA. Fetch and load 0x5555_5555 to word 3 on the same edge → returns 0xAAAA_AAAA. The next fetch returns 0x5555_5555.
- Reset mid-operation: assert reset asynchronously during streaming fetches → fetch_valid drops immediately without waiting for a clock edge. After release, a full 16-cycle sweep runs and previously loaded words read 0.
- With IMEM_PARITY_EN: load 0x1 with load_par_flip=1, then fetch it → cause 11, instr 0. Reload the same word without the flip → cause 00, instr 0x1.
